// File: rtl/timed_data_memory.sv
// Word-organised data memory on the req/gnt/rvalid protocol with parameterised grant and
// response latency. Define TIMED_DMEM_ERR_EN to add the data_err_o error response output.
module timed_data_memory #(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 32,
   parameter int MEM_WORDS    = 1024,
   parameter int GNT_DELAY    = 2,
   parameter int RVALID_DELAY = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    data_req_i,
   output logic                    data_gnt_o,
   output logic                    data_rvalid_o,
   input  logic [ADDR_WIDTH-1:0]   data_addr_i,
   input  logic                    data_we_i,
   input  logic [DATA_WIDTH/8-1:0] data_be_i,
   input  logic [DATA_WIDTH-1:0]   data_wdata_i,
   output logic [DATA_WIDTH-1:0]   data_rdata_o
`ifdef TIMED_DMEM_ERR_EN
   ,
   output logic                    data_err_o
`endif
);

   localparam int         IDX_W    = $clog2(MEM_WORDS);
   localparam logic [3:0] GNT_LOAD = 4'(GNT_DELAY);
   localparam logic [3:0] RV_LOAD  = 4'(RVALID_DELAY);

   typedef enum logic [2:0] {IDLE, WAIT_GNT, GNT, WAIT_RVALID, RVALID} state_e;

   state_e                 state_q, state_d;
   logic [3:0]             gnt_cnt_q, gnt_cnt_d;
   logic [3:0]             rv_cnt_q, rv_cnt_d;
   logic                   gnt_q, rvalid_q;
   logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
   logic [DATA_WIDTH-1:0]  resp_q;

   // NOTE: the array has no reset; the declaration initialiser gives zero power-up contents
   // and reset leaves the stored data untouched.
   logic [DATA_WIDTH-1:0]  mem_q [MEM_WORDS] = '{default: '0};

   logic [IDX_W-1:0]       word_idx;
   logic                   in_range;
   logic [DATA_WIDTH-1:0]  rd_word, resp_now;

   assign word_idx = data_addr_i[IDX_W+1:2];
   assign in_range = (data_addr_i >> (IDX_W + 2)) == '0;
   assign rd_word  = in_range ? mem_q[word_idx] : '0;
   // Writes respond with zero data, so the response is resolved once at the grant edge.
   assign resp_now = data_we_i ? '0 : rd_word;

   always_comb begin
      state_d   = state_q;
      gnt_cnt_d = gnt_cnt_q;
      rv_cnt_d  = rv_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (data_req_i) begin
               gnt_cnt_d = GNT_LOAD;
               state_d   = (GNT_LOAD == 4'd0) ? GNT : WAIT_GNT;
            end
         end
         WAIT_GNT: begin
            gnt_cnt_d = (gnt_cnt_q == 4'd0) ? 4'd0 : gnt_cnt_q - 4'd1;
            if (!data_req_i) begin
               state_d   = IDLE;
               gnt_cnt_d = '0;
            end else if (gnt_cnt_d == 4'd0) begin
               state_d = GNT;
            end
         end
         GNT: begin
            rv_cnt_d = RV_LOAD;
            state_d  = (RV_LOAD == 4'd0) ? RVALID : WAIT_RVALID;
         end
         WAIT_RVALID: begin
            rv_cnt_d = (rv_cnt_q == 4'd0) ? 4'd0 : rv_cnt_q - 4'd1;
            if (rv_cnt_d == 4'd0) state_d = RVALID;
         end
         RVALID:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // With zero response delay the response is taken straight from the bus-side lookup.
   always_comb begin
      rdata_d = '0;
      if (state_d == RVALID) rdata_d = (state_q == GNT) ? resp_now : resp_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         gnt_cnt_q <= '0;
         rv_cnt_q  <= '0;
         gnt_q     <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         resp_q    <= '0;
      end else begin
         state_q   <= state_d;
         gnt_cnt_q <= gnt_cnt_d;
         rv_cnt_q  <= rv_cnt_d;
         gnt_q     <= (state_d == GNT);
         rvalid_q  <= (state_d == RVALID);
         rdata_q   <= rdata_d;
         if (state_q == GNT) resp_q <= resp_now;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && state_q == GNT && data_we_i && in_range) begin
         for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (data_be_i[b]) mem_q[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
         end
      end
   end

   assign data_gnt_o    = gnt_q;
   assign data_rvalid_o = rvalid_q;
   assign data_rdata_o  = rdata_q;

`ifdef TIMED_DMEM_ERR_EN
   logic err_now, err_flag_q, err_q, err_d;

   assign err_now = !in_range || (data_addr_i[1:0] != 2'b00);

   always_comb begin
      err_d = 1'b0;
      if (state_d == RVALID) err_d = (state_q == GNT) ? err_now : err_flag_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_flag_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         if (state_q == GNT) err_flag_q <= err_now;
         err_q <= err_d;
      end
   end

   assign data_err_o = err_q;
`else
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^data_addr_i[1:0];
`endif

endmodule

// File: tb/tb_timed_data_memory.sv
// Directed scoreboard bench: dut0 uses the default delays, dut1 has zero grant/response delay.
module tb_timed_data_memory;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        req   = 1'b0;
   logic        sel   = 1'b0;
   logic        we    = 1'b0;
   logic [15:0] addr  = '0;
   logic [3:0]  be    = '0;
   logic [31:0] wdata = '0;

   logic        req0, req1;
   logic        gnt0, rv0, gnt1, rv1, err0, err1;
   logic [31:0] rdata0, rdata1;
   logic        cur_gnt, cur_rv, cur_err;
   logic [31:0] cur_rdata;

   int          checks = 0;
   int          errors = 0;
   resp_t       sb[$];
   logic [31:0] model [2][1024];

   always #5 clk = ~clk;

   assign req0      = req && !sel;
   assign req1      = req && sel;
   assign cur_gnt   = sel ? gnt1 : gnt0;
   assign cur_rv    = sel ? rv1 : rv0;
   assign cur_rdata = sel ? rdata1 : rdata0;
   assign cur_err   = sel ? err1 : err0;

   timed_data_memory #(.GNT_DELAY(2), .RVALID_DELAY(1)) dut0 (
      .clk_i        (clk),
      .rst_i        (rst),
      .data_req_i   (req0),
      .data_gnt_o   (gnt0),
      .data_rvalid_o(rv0),
      .data_addr_i  (addr),
      .data_we_i    (we),
      .data_be_i    (be),
      .data_wdata_i (wdata),
      .data_rdata_o (rdata0)
`ifdef TIMED_DMEM_ERR_EN
      ,
      .data_err_o   (err0)
`endif
   );

   timed_data_memory #(.GNT_DELAY(0), .RVALID_DELAY(0)) dut1 (
      .clk_i        (clk),
      .rst_i        (rst),
      .data_req_i   (req1),
      .data_gnt_o   (gnt1),
      .data_rvalid_o(rv1),
      .data_addr_i  (addr),
      .data_we_i    (we),
      .data_be_i    (be),
      .data_wdata_i (wdata),
      .data_rdata_o (rdata1)
`ifdef TIMED_DMEM_ERR_EN
      ,
      .data_err_o   (err1)
`endif
   );

`ifndef TIMED_DMEM_ERR_EN
   assign err0 = 1'b0;
   assign err1 = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One complete transaction; cycle 0 is the cycle in which the request is first driven.
   task automatic txn(input logic s, input logic w, input logic [15:0] a, input logic [3:0] b,
                      input logic [31:0] d, input int exp_g, input int exp_r, input string tag);
      resp_t       e;
      int          g_at, r_at, g_cnt;
      logic        ok;
      logic [9:0]  idx;
      ok      = (a < 16'h1000);
      idx     = a[11:2];
      e.err   = !ok || (a[1:0] != 2'b00);
      e.rdata = (w || !ok) ? 32'h0 : model[s][idx];
      if (w && ok) begin
         for (int i = 0; i < 4; i++) if (b[i]) model[s][idx][8*i +: 8] = d[8*i +: 8];
      end
      sb.push_back(e);
      sel = s; we = w; be = b; req = 1'b1;
      // Decoy bus values before the grant must have no effect.
      addr  = (exp_g > 1) ? (a ^ 16'h0100) : a;
      wdata = (exp_g > 1) ? ~d : d;
      g_at = -1; r_at = -1; g_cnt = 0;
      for (int k = 1; k <= 40 && r_at < 0; k++) begin
         @(negedge clk);
         if (k == 1) begin addr = a; wdata = d; end
         if (cur_gnt) begin
            g_cnt++;
            if (g_at < 0) g_at = k;
         end else if (g_at >= 0 && req) begin
            req   = 1'b0;
            addr  = 16'($urandom);
            wdata = $urandom;
            be    = 4'($urandom);
         end
         if (cur_rv) begin
            r_at = k;
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check({tag, " rdata"}, cur_rdata, e.rdata);
`ifdef TIMED_DMEM_ERR_EN
               check({tag, " err"}, 32'(cur_err), 32'(e.err));
`endif
            end
         end
      end
      check({tag, " gnt_cycle"}, g_at, exp_g);
      check({tag, " rvalid_cycle"}, r_at, exp_r);
      check({tag, " gnt_pulses"}, g_cnt, 1);
      if (r_at < 0) sb.delete();
      req = 1'b0;
      @(negedge clk);
      check({tag, " rvalid_pulse"}, 32'(cur_rv), 0);
   endtask

   // Full-word write on dut0 with reset asserted in cycle rst_k (3 = GNT, 4 = WAIT_RVALID).
   task automatic reset_write(input logic [15:0] a, input logic [31:0] d, input int rst_k,
                              input string tag);
      int rv_seen;
      rv_seen = 0;
      sel = 1'b0; we = 1'b1; addr = a; be = 4'hF; wdata = d; req = 1'b1;
      for (int k = 1; k <= rst_k; k++) begin
         @(negedge clk);
         if (cur_rv) rv_seen++;
      end
      check({tag, " gnt_at_reset"}, 32'(cur_gnt), (rst_k == 3) ? 32'd1 : 32'd0);
      rst = 1'b1;
      req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (cur_rv) rv_seen++;
         @(negedge clk);
      end
      check({tag, " no_rvalid"}, rv_seen, 0);
      if (rst_k > 3) model[0][a[11:2]] = d;
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 1024; i++) model[s][i] = 32'h0;
      end

      repeat (3) @(negedge clk);
      check("reset gnt0", 32'(gnt0), 0);
      check("reset rvalid0", 32'(rv0), 0);
      check("reset rdata0", rdata0, 0);
      check("reset gnt1", 32'(gnt1), 0);
      check("reset rvalid1", 32'(rv1), 0);
      check("reset err0", 32'(err0), 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle rdata0", rdata0, 0);

      txn(1'b0, 1'b0, 16'h0010, 4'hF, 32'h0,          3, 5, "rd_0010");
      txn(1'b0, 1'b1, 16'h0020, 4'hF, 32'hDEADBEEF,   3, 5, "wr_0020_full");
      txn(1'b0, 1'b0, 16'h0020, 4'hF, 32'h0,          3, 5, "rd_0020_full");
      txn(1'b0, 1'b1, 16'h0020, 4'b0101, 32'h11223344, 3, 5, "wr_0020_be");
      txn(1'b0, 1'b0, 16'h0020, 4'hF, 32'h0,          3, 5, "rd_0020_be");

      sel = 1'b0; we = 1'b1; addr = 16'h0030; be = 4'hF; wdata = 32'h55AA55AA; req = 1'b1;
      @(negedge clk);
      check("abort gnt c1", 32'(cur_gnt), 0);
      req = 1'b0;
      @(negedge clk);
      check("abort gnt c2", 32'(cur_gnt), 0);
      check("abort rvalid c2", 32'(cur_rv), 0);
      txn(1'b0, 1'b0, 16'h0030, 4'hF, 32'h0,          3, 5, "rd_after_abort");

      txn(1'b0, 1'b1, 16'h1020, 4'hF, 32'hAAAA5555,   3, 5, "wr_oor");
      txn(1'b0, 1'b0, 16'h0020, 4'hF, 32'h0,          3, 5, "rd_0020_after_oor");
      txn(1'b0, 1'b0, 16'h1000, 4'hF, 32'h0,          3, 5, "rd_oor");
      txn(1'b0, 1'b0, 16'h0022, 4'hF, 32'h0,          3, 5, "rd_misaligned");
      txn(1'b0, 1'b1, 16'h0FFC, 4'hF, 32'h0BADCAFE,   3, 5, "wr_top");
      txn(1'b0, 1'b0, 16'h0FFC, 4'hF, 32'h0,          3, 5, "rd_top");

      txn(1'b1, 1'b0, 16'h0000, 4'hF, 32'h0,          1, 2, "z_rd_0000");
      txn(1'b1, 1'b0, 16'h0004, 4'hF, 32'h0,          1, 2, "z_rd_0004");
      txn(1'b1, 1'b1, 16'h0004, 4'b1000, 32'h77123456, 1, 2, "z_wr_0004");
      txn(1'b1, 1'b0, 16'h0004, 4'hF, 32'h0,          1, 2, "z_rd_0004_after_wr");

      reset_write(16'h0040, 32'hCAFEF00D, 4, "rst_wait_rvalid");
      txn(1'b0, 1'b0, 16'h0040, 4'hF, 32'h0,          3, 5, "rd_after_rst_rv");
      reset_write(16'h0050, 32'h12345678, 3, "rst_in_gnt");
      txn(1'b0, 1'b0, 16'h0050, 4'hF, 32'h0,          3, 5, "rd_after_rst_gnt");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
